// File: rtl/clk_src_gen.sv
// -----------------------------------------------------------------------------
// clk_src_gen
//
// Purpose:
//   Produces two registered divided clocks (clk1 = fast source, clk0 = slow
//   source) plus a registered source select for a downstream glitch-free clock
//   mux. Divisors are changed through shadow registers and only take effect at
//   the end of the running period, so no output period is ever truncated. The
//   select can only change after it has held its value for MIN_DWELL cycles.
//
// Parameters:
//   DIV_W      width of divisor inputs and period counters (>= 2)
//   MIN_DWELL  minimum clk cycles sel holds between changes
//
// Ports:
//   clk      in   master clock, all state updates on its rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   divider enable; 0 freezes both divider counters and outputs
//   div1     in   requested divisor for clk1
//   div0     in   requested divisor for clk0
//   upd      in   pulse, captures div1/div0 into the shadow registers
//   sw_req   in   pulse, requests sel to change to sw_to
//   sw_to    in   requested select value
//   clk1     out  divided clock, fast source
//   clk0     out  divided clock, slow source
//   sel      out  source select for the downstream mux
//   sw_busy  out  high while a switch request waits for dwell to expire
//   sw_ack   out  one-cycle pulse when a switch request completes
// -----------------------------------------------------------------------------
module clk_src_gen #(
    parameter int DIV_W     = 8,
    parameter int MIN_DWELL = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div1,
    input  logic [DIV_W-1:0] div0,
    input  logic             upd,
    input  logic             sw_req,
    input  logic             sw_to,
    output logic             clk1,
    output logic             clk0,
    output logic             sel,
    output logic             sw_busy,
    output logic             sw_ack
);

    localparam int DWELL_W = $clog2(MIN_DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);
    localparam logic [DIV_W-1:0]   DIV_MIN   = DIV_W'(2);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Index 1 belongs to clk1, index 0 to clk0.
    logic [DIV_W-1:0] div_in  [2];
    logic [DIV_W-1:0] cnt     [2];
    logic [DIV_W-1:0] act_div [2];
    logic [DIV_W-1:0] shadow  [2];
    logic             pend    [2];
    logic             clk_q   [2];

    logic [DWELL_W-1:0] dwell;
    logic               dwell_full;

    state_t state;
    state_t state_nx;
    logic   sel_nx;
    logic   target;
    logic   target_nx;
    logic   busy_nx;
    logic   ack_nx;

    // Divisors below 2 cannot produce a toggling clock, so they act as 2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    assign div_in[1] = div1;
    assign div_in[0] = div0;
    assign clk1      = clk_q[1];
    assign clk0      = clk_q[0];

    // Two identical dividers. The output is high for the first floor(N/2)
    // counts of each period. A pending divisor is only taken on the wrap
    // edge; an upd arriving on that same edge re-arms the pending flag so the
    // newer value is applied at the following wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i]     <= '0;
                clk_q[i]   <= 1'b0;
                act_div[i] <= DIV_MIN;
                shadow[i]  <= DIV_MIN;
                pend[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (en) begin
                    clk_q[i] <= (cnt[i] < (act_div[i] >> 1));
                    if (cnt[i] == act_div[i] - DIV_W'(1)) begin
                        cnt[i] <= '0;
                        if (pend[i]) begin
                            act_div[i] <= eff_div(shadow[i]);
                            pend[i]    <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + DIV_W'(1);
                    end
                end
                if (upd) begin
                    shadow[i] <= div_in[i];
                    pend[i]   <= 1'b1;
                end
            end
        end
    end

    assign dwell_full = (dwell == DWELL_MAX);

    // Select FSM next-state logic. Requests arriving while WAIT is already
    // holding a target are dropped; the FSM is independent of en and upd.
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        target_nx = target;
        busy_nx   = sw_busy;
        ack_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (sw_req) begin
                    if (sw_to == sel) begin
                        ack_nx = 1'b1;
                    end else if (dwell_full) begin
                        sel_nx = sw_to;
                        ack_nx = 1'b1;
                    end else begin
                        target_nx = sw_to;
                        busy_nx   = 1'b1;
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dwell_full) begin
                    sel_nx   = target;
                    ack_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // Select FSM registers and dwell counter. The dwell counter restarts on
    // the very edge sel changes, so the new value is held a full MIN_DWELL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            target  <= 1'b0;
            sw_busy <= 1'b0;
            sw_ack  <= 1'b0;
            dwell   <= '0;
        end else begin
            state   <= state_nx;
            sel     <= sel_nx;
            target  <= target_nx;
            sw_busy <= busy_nx;
            sw_ack  <= ack_nx;
            if (sel_nx != sel) begin
                dwell <= '0;
            end else if (!dwell_full) begin
                dwell <= dwell + DWELL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_src_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_src_gen
//
// Purpose:
//   Self-checking bench for clk_src_gen. A behavioural model tracks each
//   divider as "position within the current period" and the select path as
//   "cycles since sel last changed", and every output is compared after every
//   clock edge. Directed scenarios cover divisor changes, enable freeze, dwell
//   timing and reset during a pending switch; a randomized phase follows.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_clk_src_gen;

    localparam int DIV_W     = 8;
    localparam int MIN_DWELL = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div1;
    logic [DIV_W-1:0] div0;
    logic             upd;
    logic             sw_req;
    logic             sw_to;
    logic             clk1;
    logic             clk0;
    logic             sel;
    logic             sw_busy;
    logic             sw_ack;

    int tests_run;
    int tests_failed;

    // Reference model state
    int m_n      [2];
    int m_pos    [2];
    int m_shadow [2];
    bit m_pend   [2];
    bit m_clk    [2];
    bit m_sel;
    bit m_busy;
    bit m_ack;
    bit m_target;
    bit m_waiting;
    int m_since;

    clk_src_gen #(
        .DIV_W     (DIV_W),
        .MIN_DWELL (MIN_DWELL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div1    (div1),
        .div0    (div0),
        .upd     (upd),
        .sw_req  (sw_req),
        .sw_to   (sw_to),
        .clk1    (clk1),
        .clk0    (clk0),
        .sel     (sel),
        .sw_busy (sw_busy),
        .sw_ack  (sw_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        int req_div [2];
        bit old_sel;
        req_div[1] = int'(div1);
        req_div[0] = int'(div0);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_n[i]      = 2;
                m_pos[i]    = 0;
                m_shadow[i] = 2;
                m_pend[i]   = 1'b0;
                m_clk[i]    = 1'b0;
            end
            m_sel     = 1'b0;
            m_busy    = 1'b0;
            m_ack     = 1'b0;
            m_target  = 1'b0;
            m_waiting = 1'b0;
            m_since   = 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (en) begin
                m_clk[i] = (m_pos[i] < m_n[i] / 2);
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == m_n[i]) begin
                    m_pos[i] = 0;
                    if (m_pend[i]) begin
                        m_n[i]    = (m_shadow[i] < 2) ? 2 : m_shadow[i];
                        m_pend[i] = 1'b0;
                    end
                end
            end
            if (upd) begin
                m_shadow[i] = req_div[i];
                m_pend[i]   = 1'b1;
            end
        end
        old_sel = m_sel;
        m_ack   = 1'b0;
        if (m_waiting) begin
            if (m_since >= MIN_DWELL) begin
                m_sel     = m_target;
                m_ack     = 1'b1;
                m_busy    = 1'b0;
                m_waiting = 1'b0;
            end
        end else if (sw_req) begin
            if (sw_to == m_sel) begin
                m_ack = 1'b1;
            end else if (m_since >= MIN_DWELL) begin
                m_sel = sw_to;
                m_ack = 1'b1;
            end else begin
                m_target  = sw_to;
                m_busy    = 1'b1;
                m_waiting = 1'b1;
            end
        end
        if (m_sel != old_sel) m_since = 0;
        else if (m_since < 1000) m_since = m_since + 1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("clk1", clk1, m_clk[1]);
        check("clk0", clk0, m_clk[0]);
        check("sel", sel, m_sel);
        check("sw_busy", sw_busy, m_busy);
        check("sw_ack", sw_ack, m_ack);
    endtask

    // One rising edge: model follows the DUT, outputs checked 1 time unit later.
    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    initial begin
        int cycles;
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        div1   = '0;
        div0   = '0;
        upd    = 1'b0;
        sw_req = 1'b0;
        sw_to  = 1'b0;

        // Reset state
        run(2);
        check("rst_clk1", clk1, 1'b0);
        check("rst_sel", sel, 1'b0);
        check("rst_busy", sw_busy, 1'b0);

        // div1=2, div0=4 loaded on the first enabled edge
        rst_n = 1'b1;
        en    = 1'b1;
        div1  = 8'd2;
        div0  = 8'd4;
        upd   = 1'b1;
        apply_stimulus();
        upd = 1'b0;
        check("first_rise_clk1", clk1, 1'b1);
        check("first_rise_clk0", clk0, 1'b1);
        apply_stimulus();
        check("clk0_old_period_low", clk0, 1'b0);
        run(2);
        check("clk0_new_period_high", clk0, 1'b1);
        run(20);

        // div0=5 mid-period, then div1=0 and div1=1
        run(1);
        div0 = 8'd5;
        div1 = 8'd0;
        upd  = 1'b1;
        apply_stimulus();
        upd = 1'b0;
        run(30);
        div1 = 8'd1;
        upd  = 1'b1;
        apply_stimulus();
        upd = 1'b0;
        run(12);

        // Enable dropped for 7 cycles mid-period
        run(3);
        en = 1'b0;
        run(7);
        en = 1'b1;
        run(15);

        // Switch request on the 5th edge after reset release
        rst_n = 1'b0;
        apply_stimulus();
        rst_n = 1'b1;
        run(4);
        sw_req = 1'b1;
        sw_to  = 1'b1;
        apply_stimulus();
        sw_req = 1'b0;
        check("dwell_busy_set", sw_busy, 1'b1);
        for (int e = 6; e <= 16; e++) begin
            apply_stimulus();
            check("dwell_sel_held", sel, 1'b0);
            check("dwell_busy_held", sw_busy, 1'b1);
        end
        apply_stimulus();
        check("dwell_sel_switch", sel, 1'b1);
        check("dwell_ack", sw_ack, 1'b1);
        check("dwell_busy_clear", sw_busy, 1'b0);
        apply_stimulus();
        check("dwell_ack_single", sw_ack, 1'b0);

        // Same-value request: ack only, dwell keeps counting
        run(20);
        sw_req = 1'b1;
        sw_to  = 1'b1;
        apply_stimulus();
        check("same_ack", sw_ack, 1'b1);
        check("same_sel", sel, 1'b1);
        check("same_busy", sw_busy, 1'b0);
        sw_to = 1'b0;
        apply_stimulus();
        sw_req = 1'b0;
        check("immediate_switch_sel", sel, 1'b0);
        check("immediate_switch_ack", sw_ack, 1'b1);
        apply_stimulus();

        // Reset while waiting drops the switch
        sw_req = 1'b1;
        sw_to  = 1'b1;
        apply_stimulus();
        sw_req = 1'b0;
        check("wait_entered", sw_busy, 1'b1);
        run(5);
        rst_n = 1'b0;
        apply_stimulus();
        check("rst_wait_sel", sel, 1'b0);
        check("rst_wait_busy", sw_busy, 1'b0);
        check("rst_wait_ack", sw_ack, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        sw_req = 1'b1;
        sw_to  = 1'b1;
        cycles = 0;
        apply_stimulus();
        sw_req = 1'b0;
        cycles = 1;
        while (sel !== 1'b1 && cycles < 40) begin
            apply_stimulus();
            cycles++;
        end
        tests_run++;
        assert (cycles == MIN_DWELL + 1) else begin
            tests_failed++;
            $error("FAIL post_reset_dwell observed=%0d expected=%0d", cycles, MIN_DWELL + 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            en     = ($urandom_range(0, 9) != 0);
            upd    = ($urandom_range(0, 14) == 0);
            div1   = DIV_W'($urandom_range(0, 9));
            div0   = DIV_W'($urandom_range(0, 12));
            sw_req = ($urandom_range(0, 7) == 0);
            sw_to  = 1'($urandom_range(0, 1));
            apply_stimulus();
        end
        rst_n  = 1'b1;
        upd    = 1'b0;
        sw_req = 1'b0;
        run(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clk_src_gen.md
CLK_SRC_GEN -- requirements
Module: clk_src_gen

Interface
REQ-001 Parameter DIV_W, default 8: width of divisor inputs and period counters.
REQ-002 Parameter MIN_DWELL, default 16: minimum clk cycles sel SHALL hold between changes.
REQ-003 clk  in  1  single master clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 en  in  1  divider enable; 0 freezes both divider counters and outputs.
REQ-006 div1  in  DIV_W  requested divisor for clk1.
REQ-007 div0  in  DIV_W  requested divisor for clk0.
REQ-008 upd  in  1  pulse; captures div1/div0 into shadow registers.
REQ-009 sw_req  in  1  pulse; request sel change to sw_to.
REQ-010 sw_to  in  1  target select value.
REQ-011 clk1  out  1  registered divided clock, fast source to the downstream glitch-free mux.
REQ-012 clk0  out  1  registered divided clock, slow source to the downstream mux.
REQ-013 sel  out  1  registered source select to the downstream mux.
REQ-014 sw_busy  out  1  high while a switch request waits for dwell.
REQ-015 sw_ack  out  1  one-cycle pulse on switch completion.

Function
REQ-016 Effective divisor N SHALL be max(div,2); divisor values 0 and 1 SHALL act as 2.
REQ-017 Each divider SHALL keep counter cnt in 0..N-1 and H = floor(N/2).
REQ-018 On each edge with en=1, clkX SHALL be loaded with (cnt < H), and cnt SHALL advance (N-1 wraps to 0). Result: H cycles high, N-H cycles low, first rise on the first enabled edge.
REQ-019 With en=0, cnt, clk1 and clk0 SHALL hold.
REQ-020 On upd=1, shadows SHALL capture div1/div0 and set per-divider pending flags; a later upd before application SHALL overwrite the shadow.
REQ-021 A pending divisor SHALL load into the active divisor only on the edge where that divider wraps (cnt==N-1, en=1). The pending flag clears on that edge, so no period is truncated.
REQ-022 Dwell counter d SHALL increment each edge, saturating at MIN_DWELL, and load 0 on any edge where sel changes.
REQ-023 FSM states: IDLE, WAIT.
REQ-024 IDLE, sw_req=1, sw_to==sel: sel SHALL be unchanged and sw_ack SHALL be 1 on the following cycle.
REQ-025 IDLE, sw_req=1, sw_to!=sel, d==MIN_DWELL: sel<=sw_to and sw_ack<=1 on the same edge.
REQ-026 IDLE, sw_req=1, sw_to!=sel, d<MIN_DWELL: latch target, sw_busy<=1, go to WAIT.
REQ-027 WAIT: on the first edge with d==MIN_DWELL, sel<=target, sw_ack<=1, sw_busy<=0, return to IDLE.
REQ-028 sw_req while in WAIT SHALL be ignored; en and upd SHALL NOT affect the select FSM.

Reset
REQ-029 On an edge with rst_n=0 the following SHALL hold:
- cnt=0, clk1=0, clk0=0;
- active divisors=2, shadows=2, pending flags=0;
- sel=0, d=0, FSM=IDLE, sw_busy=0, sw_ack=0.
REQ-030 Reset mid-WAIT SHALL drop the pending switch with no sw_ack.
REQ-031 Reset mid-period SHALL drop any pending divisor.

Verification
REQ-032 Reset; en=1; upd with div1=2, div0=4 -> clk1 1 high/1 low continuously; clk0 1/1 until its first wrap, then 2 high/2 low.
REQ-033 div0=5 applied via upd during an active period -> current period completes unchanged, then clk0 2 high/3 low; div1=0 or 1 -> clk1 period 2.
REQ-034 en dropped mid-period for 7 cycles -> clk1/clk0 and counters hold, then resume with the same phase.
REQ-035 MIN_DWELL=16; sw_req with sw_to=1 on the 5th edge after rst_n high -> sw_busy high from that edge, sel=1 and sw_ack pulse on the 17th edge, sw_busy low on the same edge.
REQ-036 sw_req with sw_to==sel -> single sw_ack pulse, sel unchanged, sw_busy never high, d not cleared.
REQ-037 rst_n=0 for one edge while in WAIT -> sel=0, sw_busy=0, no sw_ack; next switch needs 16 full dwell cycles.
